// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: waits for an idle bus, then clocks one
// 11-bit frame (start, 8 data bits LSB first, odd parity, stop) onto the
// open-drain PS2_CLK/PS2_DATA lines. Backs off and restarts when the host
// inhibits the bus before the stop bit.
module ps2_dev_tx #(
  parameter int unsigned HALF     = 2500,
  parameter int unsigned IDLE_CYC = 2500
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_BIT_HI = 3'd2;
  localparam logic [2:0] S_BIT_LO = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] IDLE_LIM  = 16'(IDLE_CYC);
  // Our own released clock needs two synchronizer stages to read back high,
  // so a low sample earlier than this in BIT_HI may be our own echo.
  localparam logic [15:0] INHIBIT_MIN = 16'd3;
  localparam logic [3:0]  LAST_BIT    = 4'd10;
  localparam logic [3:0]  LAST_ABORTABLE = 4'd9;

  logic [1:0]  clkSync_q;
  logic [1:0]  dataSync_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic        clkSync;
  logic        dataSync;
  logic [10:0] frameBits;
  logic        curBit;

  assign clkSync  = clkSync_q[1];
  assign dataSync = dataSync_q[1];

  // Frame as sent on the wire, bit 0 first; parity makes the total count of ones odd.
  assign frameBits = {1'b1, ~^byte_q, byte_q, 1'b0};
  assign curBit    = frameBits[idx_q];

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = (state_q == S_BIT_LO);
  assign ps2_data_oe = ((state_q == S_BIT_HI) || (state_q == S_BIT_LO)) && !curBit;
  assign done        = done_q;
  assign abort       = abort_q;

  // Two-flop synchronizers for the asynchronous bus lines, idling high like the pulled-up bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_i};
      dataSync_q <= {dataSync_q[0], ps2_data_i};
    end
  end

  // Next-state logic: idle-bus wait, half-period sequencing and host-inhibit back-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          byte_d  = tx_data;
          state_d = S_CHECK;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end
      end
      S_CHECK: begin
        if (!(clkSync && dataSync)) begin
          cnt_d = 16'd0;
        end else if (cnt_q >= IDLE_LIM) begin
          state_d = S_BIT_HI;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_HI: begin
        if ((idx_q <= LAST_ABORTABLE) && (cnt_q >= INHIBIT_MIN) && !clkSync) begin
          state_d = S_CHECK;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
          abort_d = 1'b1;
        end else if (cnt_q == HALF_LAST) begin
          state_d = S_BIT_LO;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 16'd0;
          if (idx_q == LAST_BIT) begin
            state_d = S_GAP;
          end else begin
            state_d = S_BIT_HI;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State registers; reset drops the frame and releases the bus at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 4'd0;
      byte_q  <= 8'd0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: each byte issued pushes its expected
// frame, a host model collects the bits the device clocks out, and a
// monitor compares them (plus timing) whenever done pulses.
module tb_ps2_dev_tx;

  localparam int HALF       = 4;
  localparam int IDLE       = 8;
  localparam int LAT_FIRST  = IDLE + HALF + 1;
  localparam int LAT_DONE   = IDLE + 23 * HALF + 1;
  localparam int LAT_REL    = IDLE + HALF + 3;
  localparam int WAIT_LIMIT = 2000;

  typedef struct {
    logic [10:0] bits;
    bit          checkLat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] txData = 8'd0;
  logic       txValid = 1'b0;
  logic       txReady;
  logic       ps2ClkOe;
  logic       ps2DataOe;
  logic       busy;
  logic       done;
  logic       abort;
  logic       hostClkPull = 1'b0;
  logic       hostDataPull = 1'b0;
  logic       ps2ClkLine;
  logic       ps2DataLine;

  exp_t expQ[$];
  logic sampled[$];
  exp_t monE;
  logic [10:0] gotBits;

  int checks = 0;
  int passes = 0;
  int edgeNum = 0;
  int acceptEdge = 0;
  int lastDoneEdge = -100;
  int doneCount = 0;
  int abortCount = 0;
  int relEdge = 0;
  bit inFrame = 1'b0;
  bit latCheck = 1'b0;
  bit nextLatCheck = 1'b0;
  bit firstPending = 1'b0;

  // Open-drain bus with pull-ups: a line is low if either side pulls it.
  assign ps2ClkLine  = ~(ps2ClkOe | hostClkPull);
  assign ps2DataLine = ~(ps2DataOe | hostDataPull);

  ps2_dev_tx #(.HALF(HALF), .IDLE_CYC(IDLE)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (txData),
    .tx_valid   (txValid),
    .tx_ready   (txReady),
    .ps2_clk_i  (ps2ClkLine),
    .ps2_data_i (ps2DataLine),
    .ps2_clk_oe (ps2ClkOe),
    .ps2_data_oe(ps2DataOe),
    .busy       (busy),
    .done       (done),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  // Reference frame from the protocol rules: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] refFrame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = $countones(b);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    f[9] = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Edge counter and accept detection, evaluated with pre-edge DUT values.
  always @(posedge clk) begin
    edgeNum++;
    if (rstn && txValid && txReady) begin
      acceptEdge   = edgeNum;
      inFrame      = 1'b1;
      latCheck     = nextLatCheck;
      firstPending = 1'b1;
    end
  end

  // Host model: the data line is read where the device drives the clock low.
  always @(posedge ps2ClkOe) begin
    if (rstn) sampled.push_back(ps2DataLine);
  end

  // Monitor: compares collected frames and timing against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (done) begin
        doneCount++;
        lastDoneEdge = edgeNum;
        inFrame = 1'b0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", doneCount, doneCount - 1);
        end else begin
          monE = expQ.pop_front();
          gotBits = 11'h7ff;
          for (int i = 0; i < sampled.size() && i < 11; i++) gotBits[i] = sampled[i];
          checkOutput("frame_bits", int'(gotBits), int'(monE.bits));
          checkOutput("bit_count", sampled.size(), 11);
          if (monE.checkLat) checkOutput("done_latency", edgeNum - acceptEdge, LAT_DONE);
        end
        sampled.delete();
      end
      if (abort) begin
        abortCount++;
        sampled.delete();
        checkOutput("oe_after_abort", int'({ps2ClkOe, ps2DataOe}), 0);
      end
      if (ps2ClkOe && firstPending) begin
        firstPending = 1'b0;
        if (latCheck) checkOutput("first_clk_latency", edgeNum - acceptEdge, LAT_FIRST);
      end
      checkOutput("ready_busy", int'({txReady, busy}), int'({!inFrame, inFrame}));
    end
  end

  // Issue one byte: push its expected frame, then hold tx_valid until accepted.
  task automatic applyStimulus(input logic [7:0] b, input bit lat, input bit dropValid);
    exp_t e;
    int n;
    e.bits = refFrame(b);
    e.checkLat = lat;
    expQ.push_back(e);
    nextLatCheck = lat;
    @(negedge clk);
    txData = b;
    txValid = 1'b1;
    n = 0;
    while (!txReady && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_timeout", int'(txReady), 1);
    @(negedge clk);
    if (dropValid) txValid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (doneCount < target && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_count", doneCount, target);
  endtask

  // Wait until the device clock output has made k rising (rise=1) or falling edges.
  task automatic waitOeEdges(input int k, input bit rise);
    int n, cnt;
    logic prev;
    n = 0;
    cnt = 0;
    prev = ps2ClkOe;
    while (cnt < k && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
      if (rise && ps2ClkOe && !prev) cnt++;
      if (!rise && !ps2ClkOe && prev) cnt++;
      prev = ps2ClkOe;
    end
    checkOutput("oe_edge_wait", cnt, k);
  endtask

  task automatic waitFirstClkAfterRelease();
    int n;
    n = 0;
    while (!ps2ClkOe && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_after_release", edgeNum - relEdge, LAT_REL);
  endtask

  initial begin
    int target;
    int ab;
    bit sawOe;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'({ps2ClkOe, ps2DataOe, busy, done, abort, txReady}), 1);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Known byte with latency checks.
    target = doneCount + 1;
    applyStimulus(8'h1C, 1'b1, 1'b1);
    waitDone(target);

    // Back-to-back bytes with tx_valid held throughout.
    target = doneCount + 2;
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    checkOutput("b2b_accept_gap", acceptEdge - lastDoneEdge, 1);
    waitDone(target);

    // Randomized bytes with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      target = doneCount + 1;
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      waitDone(target);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Host inhibits during bit 4: one abort, full resend after the bus idles.
    target = doneCount + 1;
    ab = abortCount;
    applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    waitOeEdges(4, 1'b0);
    hostClkPull = 1'b1;
    repeat (100) @(negedge clk);
    hostClkPull = 1'b0;
    relEdge = edgeNum;
    waitFirstClkAfterRelease();
    waitDone(target);
    checkOutput("abort_count_bit4", abortCount - ab, 1);

    // Host inhibits during bit 10: ignored, timing unchanged.
    target = doneCount + 1;
    ab = abortCount;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    waitOeEdges(10, 1'b0);
    hostClkPull = 1'b1;
    repeat (6) @(negedge clk);
    hostClkPull = 1'b0;
    waitDone(target);
    checkOutput("abort_count_bit10", abortCount - ab, 0);

    // Data line held low before the frame: device waits, then starts after release.
    target = doneCount + 1;
    hostDataPull = 1'b1;
    applyStimulus(8'h3C, 1'b0, 1'b1);
    sawOe = 1'b0;
    repeat (30) begin
      @(negedge clk);
      sawOe |= (ps2ClkOe | ps2DataOe);
    end
    checkOutput("oe_while_data_held", int'(sawOe), 0);
    checkOutput("busy_while_data_held", int'(busy), 1);
    hostDataPull = 1'b0;
    relEdge = edgeNum;
    waitFirstClkAfterRelease();
    waitDone(target);

    // Reset during BIT_LO of bit 6: lines released at once, no done or abort.
    applyStimulus(8'h96, 1'b1, 1'b1);
    waitOeEdges(7, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("oe_in_reset", int'({ps2ClkOe, ps2DataOe}), 0);
    expQ.delete();
    sampled.delete();
    inFrame = 1'b0;
    firstPending = 1'b0;
    target = doneCount;
    ab = abortCount;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("no_done_after_reset", doneCount, target);
    checkOutput("no_abort_after_reset", abortCount, ab);
    checkOutput("ready_after_reset", int'(txReady), 1);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    checks++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
